// File: rtl/cache_pkg.sv
// Shared constants and types for the direct-mapped word cache.
// Holds the geometry constants, the line record, the controller state
// encoding and helpers that split a word address (byte address [31:2])
// into its index and tag fields.
// Optional feature macro used by the slice: CACHE_STATS_EN.
package cache_pkg;

  localparam int INDEX_BITS = 10;
  localparam int TAG_BITS   = 30 - INDEX_BITS;
  localparam int DATA_BITS  = 32;

  typedef struct packed {
    logic                 valid;
    logic [TAG_BITS-1:0]  tag;
    logic [DATA_BITS-1:0] data;
  } cache_line_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    MISS   = 2'd2
  } state_t;

  // word_addr is the byte address with its two offset bits already dropped
  function automatic logic [INDEX_BITS-1:0] addr_index(input logic [29:0] word_addr);
    return word_addr[INDEX_BITS-1:0];
  endfunction

  function automatic logic [TAG_BITS-1:0] addr_tag(input logic [29:0] word_addr);
    return word_addr[29:INDEX_BITS];
  endfunction

endpackage

// File: rtl/cache_fill_ctrl_if.sv
// CPU load port and main-memory read port of the cache fill controller.
// slave  : the controller side (takes requests, issues memory reads).
// master : the environment side (CPU + memory model).
// Signals: cpu_req/cpu_addr/cpu_ready request handshake, cpu_rvalid/
// cpu_rdata/cpu_hit response, cache_flush level, mem_req/mem_addr/
// mem_ack/mem_rdata memory read.
interface cache_fill_ctrl_if import cache_pkg::*; ();

  logic                 cpu_req;
  logic [31:0]          cpu_addr;
  logic                 cpu_ready;
  logic                 cpu_rvalid;
  logic [DATA_BITS-1:0] cpu_rdata;
  logic                 cpu_hit;
  logic                 cache_flush;
  logic                 mem_req;
  logic [31:0]          mem_addr;
  logic                 mem_ack;
  logic [DATA_BITS-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_addr, cache_flush, mem_ack, mem_rdata,
    output cpu_ready, cpu_rvalid, cpu_rdata, cpu_hit, mem_req, mem_addr
  );

  modport master (
    output cpu_req, cpu_addr, cache_flush, mem_ack, mem_rdata,
    input  cpu_ready, cpu_rvalid, cpu_rdata, cpu_hit, mem_req, mem_addr
  );

endinterface

// File: rtl/cache_line_array.sv
// Line storage of the direct-mapped cache.
// Valid bits are flops with async reset and a single-cycle clear-all;
// tag and data live in an unreset memory with one combinational read
// port and one synchronous write port.
// Ports: clk, rst, clear_all, wr_en/wr_index/wr_tag/wr_data (write),
// rd_index -> rd_line (read).
module cache_line_array import cache_pkg::*; (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear_all,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_index,
  input  logic [TAG_BITS-1:0]   wr_tag,
  input  logic [DATA_BITS-1:0]  wr_data,
  input  logic [INDEX_BITS-1:0] rd_index,
  output cache_line_t           rd_line
);

  localparam int LINES = 1 << INDEX_BITS;

  logic [LINES-1:0]     valid_r;
  logic [TAG_BITS-1:0]  tag_mem_r  [LINES];
  logic [DATA_BITS-1:0] data_mem_r [LINES];

  // Valid bits: cleared by reset or flush, set by a fill
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r <= {LINES{1'b0}};
    end else if (clear_all) begin
      valid_r <= {LINES{1'b0}};
    end else if (wr_en) begin
      valid_r[wr_index] <= 1'b1;
    end else begin
      valid_r <= valid_r;
    end
  end

  // Tag/data write port; contents are don't-care until the valid bit is set
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem_r[wr_index]  <= wr_tag;
      data_mem_r[wr_index] <= wr_data;
    end
  end

  // Combinational read port
  always_comb begin
    rd_line.valid = valid_r[rd_index];
    rd_line.tag   = tag_mem_r[rd_index];
    rd_line.data  = data_mem_r[rd_index];
  end

endmodule

// File: rtl/cache_fill_ctrl.sv
// Fill/write side of the direct-mapped word cache.
// Accepts CPU reads in IDLE, looks the line up one cycle later and either
// returns the stored word (hit) or fetches it from main memory, writes the
// line and returns the fetched word (miss).
// Ports: clk, rst (async, active high), bus (cache_fill_ctrl_if.slave).
// With CACHE_STATS_EN defined: hit_count / miss_count outputs, cleared by
// reset and by a flush.
module cache_fill_ctrl import cache_pkg::*; (
  input  logic                clk,
  input  logic                rst,
  cache_fill_ctrl_if.slave    bus
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]         hit_count,
  output logic [31:0]         miss_count
`endif
);

  state_t               state_r;
  logic [29:0]          addr_r;       // latched word address, cpu_addr[31:2]
  logic                 cpu_rvalid_r;
  logic [DATA_BITS-1:0] cpu_rdata_r;
  logic                 cpu_hit_r;
  logic                 mem_req_r;
  logic [31:0]          mem_addr_r;
  cache_line_t          rd_line_s;
  logic                 hit_s;
  logic                 flush_s;
  logic                 fill_s;
`ifdef CACHE_STATS_EN
  logic [31:0]          hit_count_r;
  logic [31:0]          miss_count_r;
`endif

  // Flush only takes effect in IDLE; later it is held by the source
  assign flush_s = (state_r == IDLE) & bus.cache_flush;
  assign fill_s  = (state_r == MISS) & bus.mem_ack;
  assign hit_s   = rd_line_s.valid & (rd_line_s.tag == addr_tag(addr_r));

  cache_line_array u_array (
    .clk       (clk),
    .rst       (rst),
    .clear_all (flush_s),
    .wr_en     (fill_s),
    .wr_index  (addr_index(addr_r)),
    .wr_tag    (addr_tag(addr_r)),
    .wr_data   (bus.mem_rdata),
    .rd_index  (addr_index(addr_r)),
    .rd_line   (rd_line_s)
  );

  // Controller FSM with registered response and memory request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      addr_r       <= 30'd0;
      cpu_rvalid_r <= 1'b0;
      cpu_rdata_r  <= {DATA_BITS{1'b0}};
      cpu_hit_r    <= 1'b0;
      mem_req_r    <= 1'b0;
      mem_addr_r   <= 32'd0;
`ifdef CACHE_STATS_EN
      hit_count_r  <= 32'd0;
      miss_count_r <= 32'd0;
`endif
    end else begin
      cpu_rvalid_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.cache_flush) begin
`ifdef CACHE_STATS_EN
            hit_count_r  <= 32'd0;
            miss_count_r <= 32'd0;
`endif
          end else if (bus.cpu_req) begin
            addr_r  <= bus.cpu_addr[31:2];
            state_r <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit_s) begin
            cpu_rvalid_r <= 1'b1;
            cpu_rdata_r  <= rd_line_s.data;
            cpu_hit_r    <= 1'b1;
            state_r      <= IDLE;
`ifdef CACHE_STATS_EN
            hit_count_r  <= hit_count_r + 32'd1;
`endif
          end else begin
            mem_req_r  <= 1'b1;
            mem_addr_r <= {addr_r, 2'b00};
            state_r    <= MISS;
          end
        end
        MISS: begin
          // mem_req/mem_addr stay put until the memory answers
          if (bus.mem_ack) begin
            cpu_rvalid_r <= 1'b1;
            cpu_rdata_r  <= bus.mem_rdata;
            cpu_hit_r    <= 1'b0;
            mem_req_r    <= 1'b0;
            state_r      <= IDLE;
`ifdef CACHE_STATS_EN
            miss_count_r <= miss_count_r + 32'd1;
`endif
          end
        end
        default: begin
          mem_req_r <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

  assign bus.cpu_ready  = (state_r == IDLE) & ~bus.cache_flush;
  assign bus.cpu_rvalid = cpu_rvalid_r;
  assign bus.cpu_rdata  = cpu_rdata_r;
  assign bus.cpu_hit    = cpu_hit_r;
  assign bus.mem_req    = mem_req_r;
  assign bus.mem_addr   = mem_addr_r;
`ifdef CACHE_STATS_EN
  assign hit_count      = hit_count_r;
  assign miss_count     = miss_count_r;
`endif

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Directed testbench for cache_fill_ctrl. Inputs change #1 after a rising
// edge or on the falling edge; outputs are sampled on the falling edge.
module tb_cache_fill_ctrl;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_miss;
  int   exp_hits;
  int   exp_misses;
`ifdef CACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  cache_fill_ctrl_if bus ();

  cache_fill_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus)
`ifdef CACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_stats(input string tag);
`ifdef CACHE_STATS_EN
    check({tag, "_hits"},   64'(hit_count),  64'(exp_hits));
    check({tag, "_misses"}, 64'(miss_count), 64'(exp_misses));
`else
    $display("%s: stats counters not built", tag);
`endif
  endtask

  // One complete read; on a miss the memory answers lat cycles after mem_req
  task automatic read_word(input string tag, input logic [31:0] addr, input logic exp_hit,
                           input logic [31:0] data, input int lat);
    int cyc;
    @(negedge clk);
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = addr;
    cyc = 0;
    while (!bus.cpu_ready && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_ready"}, 64'(bus.cpu_ready), 64'd1);
    @(posedge clk);
    #1 bus.cpu_req = 1'b0;
    @(negedge clk);
    check({tag, "_lookup_rvalid"}, 64'(bus.cpu_rvalid), 64'd0);
    check({tag, "_lookup_mreq"},   64'(bus.mem_req),    64'd0);
    if (exp_hit) begin
      @(negedge clk);
      check({tag, "_rvalid"}, 64'(bus.cpu_rvalid), 64'd1);
      check({tag, "_hit"},    64'(bus.cpu_hit),    64'd1);
      check({tag, "_rdata"},  64'(bus.cpu_rdata),  64'(data));
      check({tag, "_no_mreq"}, 64'(bus.mem_req),   64'd0);
      exp_hits++;
    end else begin
      @(negedge clk);
      check({tag, "_mreq"},  64'(bus.mem_req),  64'd1);
      check({tag, "_maddr"}, 64'(bus.mem_addr), 64'({addr[31:2], 2'b00}));
      repeat (lat - 1) @(negedge clk);
      check({tag, "_mreq_held"},  64'(bus.mem_req),    64'd1);
      check({tag, "_maddr_held"}, 64'(bus.mem_addr),   64'({addr[31:2], 2'b00}));
      check({tag, "_wait_rvalid"}, 64'(bus.cpu_rvalid), 64'd0);
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = data;
      @(posedge clk);
      #1 bus.mem_ack = 1'b0;
      bus.mem_rdata  = 32'h0;
      @(negedge clk);
      check({tag, "_rvalid"}, 64'(bus.cpu_rvalid), 64'd1);
      check({tag, "_hit"},    64'(bus.cpu_hit),    64'd0);
      check({tag, "_rdata"},  64'(bus.cpu_rdata),  64'(data));
      check({tag, "_mreq_drop"}, 64'(bus.mem_req), 64'd0);
      exp_misses++;
    end
    @(negedge clk);
    check({tag, "_pulse_end"}, 64'(bus.cpu_rvalid), 64'd0);
  endtask

  initial begin
    n_vec = 0; n_miss = 0; exp_hits = 0; exp_misses = 0;
    rst = 1'b1;
    bus.cpu_req = 1'b0; bus.cpu_addr = 32'h0; bus.cache_flush = 1'b0;
    bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_rvalid", 64'(bus.cpu_rvalid), 64'd0);
    check("rst_rdata",  64'(bus.cpu_rdata),  64'd0);
    check("rst_hit",    64'(bus.cpu_hit),    64'd0);
    check("rst_mreq",   64'(bus.mem_req),    64'd0);
    check("rst_maddr",  64'(bus.mem_addr),   64'd0);
    check("rst_ready",  64'(bus.cpu_ready),  64'd1);
    check_stats("rst");

    read_word("cold_1004", 32'h0000_1004, 1'b0, 32'hDEAD_BEEF, 3);
    read_word("hit_1004",  32'h0000_1004, 1'b1, 32'hDEAD_BEEF, 0);
    read_word("hit_1007",  32'h0000_1007, 1'b1, 32'hDEAD_BEEF, 0);

    // response fields hold between pulses; a stray mem_ack in IDLE does nothing
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h5A5A_5A5A;
    @(posedge clk);
    #1 bus.mem_ack = 1'b0;
    @(negedge clk);
    check("idle_ack_rvalid", 64'(bus.cpu_rvalid), 64'd0);
    check("idle_ack_mreq",   64'(bus.mem_req),    64'd0);
    check("hold_rdata",      64'(bus.cpu_rdata),  64'h0000_0000_DEAD_BEEF);
    check("hold_hit",        64'(bus.cpu_hit),    64'd1);

    read_word("conf_2004",  32'h0000_2004, 1'b0, 32'h1234_5678, 1);
    read_word("evict_1004", 32'h0000_1004, 1'b0, 32'hCAFE_F00D, 2);
    read_word("rehit_1004", 32'h0000_1004, 1'b1, 32'hCAFE_F00D, 0);
    check_stats("pre_flush");

    // flush and request together: flush wins, request taken the next cycle
    @(negedge clk);
    bus.cache_flush = 1'b1;
    bus.cpu_req     = 1'b1;
    bus.cpu_addr    = 32'h0000_2004;
    #1 check("flush_ready", 64'(bus.cpu_ready), 64'd0);
    @(posedge clk);
    #1 bus.cache_flush = 1'b0;
    exp_hits = 0; exp_misses = 0;
    check_stats("post_flush");
    read_word("flush_2004", 32'h0000_2004, 1'b0, 32'h1234_5678, 1);
    read_word("flush_1004", 32'h0000_1004, 1'b0, 32'hCAFE_F00D, 1);
    check_stats("after_flush_reads");

    // reset while a memory read is outstanding
    @(negedge clk);
    bus.cpu_req = 1'b1; bus.cpu_addr = 32'h0000_3008;
    @(posedge clk);
    #1 bus.cpu_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("miss_mreq", 64'(bus.mem_req), 64'd1);
    #2 rst = 1'b1;
    #1 check("async_rst_mreq", 64'(bus.mem_req), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_hits = 0; exp_misses = 0;
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h5555_5555;
    @(posedge clk);
    #1 bus.mem_ack = 1'b0;
    @(negedge clk);
    check("late_ack_rvalid", 64'(bus.cpu_rvalid), 64'd0);
    check("late_ack_rdata",  64'(bus.cpu_rdata),  64'd0);
    check("late_ack_mreq",   64'(bus.mem_req),    64'd0);
    read_word("rst_2004", 32'h0000_2004, 1'b0, 32'h1234_5678, 2);
    read_word("rst_3008", 32'h0000_3008, 1'b0, 32'h0BAD_F00D, 1);
    read_word("hit_3008", 32'h0000_3008, 1'b1, 32'h0BAD_F00D, 0);
    check_stats("final");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
